// File: rtl/secure_uart_framer_pkg.sv
// secure_uart_framer_pkg: shared sync default, FSM state type and frame length helper
package secure_uart_framer_pkg;
    localparam logic [7:0] SYNC_DEFAULT = 8'h7E;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GUARD = 2'd2, WAIT = 2'd3} state_t;
    function automatic int frame_len(input int payload_bytes);
        return payload_bytes + 3;
    endfunction
endpackage

// File: rtl/secure_uart_framer_if.sv
// secure_uart_framer_if: sample strobe in (in_valid/in_ready/payload/checksum), UART byte out (tx_data/tx_start/tx_busy), status (frame_done/seq_num/drop_cnt)
interface secure_uart_framer_if #(parameter int PAYLOAD_BYTES = 2, parameter int DROP_CNT_W = 8);
    logic                       in_valid;
    logic                       in_ready;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic [7:0]                 checksum;
    logic [7:0]                 tx_data;
    logic                       tx_start;
    logic                       tx_busy;
    logic                       frame_done;
    logic [7:0]                 seq_num;
    logic [DROP_CNT_W-1:0]      drop_cnt;
    modport master (output in_valid, payload, checksum, tx_busy,
                    input in_ready, tx_data, tx_start, frame_done, seq_num, drop_cnt);
    modport slave  (input in_valid, payload, checksum, tx_busy,
                    output in_ready, tx_data, tx_start, frame_done, seq_num, drop_cnt);
endinterface

// File: rtl/secure_uart_framer_byte_sel.sv
// frame_byte_sel: byte index (in idx) -> frame byte (out byte_out) from seq/payload/checksum, FCS = xor of seq, payload bytes, checksum
module frame_byte_sel import secure_uart_framer_pkg::*; #(
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT
) (
    input  logic [3:0]                 idx,
    input  logic [7:0]                 seq,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic [7:0]                 checksum,
    output logic [7:0]                 byte_out
);
    logic [7:0]   fcs;
    logic [127:0] frame;
    always_comb begin
        fcs = seq ^ checksum;
        for (int i = 0; i < PAYLOAD_BYTES; i++) fcs = fcs ^ payload[8*i +: 8];
        frame = '0;
        frame[7:0] = SYNC_BYTE;
        frame[15:8] = seq;
        frame[16 +: 8*PAYLOAD_BYTES] = payload;
        frame[8*(PAYLOAD_BYTES+2) +: 8] = fcs;
        byte_out = frame[{idx, 3'b000} +: 8];
    end
endmodule

// File: rtl/secure_uart_framer.sv
// secure_uart_framer: frames samples (clk, async rst, bus.slave) as SYNC, SEQ, payload LSB first, FCS onto a start/busy UART with a 1-deep pending slot
module secure_uart_framer import secure_uart_framer_pkg::*; #(
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
    parameter int         DROP_CNT_W    = 8
) (
    input logic                 clk,
    input logic                 rst,
    secure_uart_framer_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(frame_len(PAYLOAD_BYTES) - 1);
    localparam int         PW       = 8 * PAYLOAD_BYTES;
    state_t        state;
    logic [3:0]    byte_idx;
    logic [PW-1:0] act_payload, pend_payload;
    logic [7:0]    act_chk, pend_chk, cur_byte;
    logic          pend_valid, accept, done_now;
    assign bus.in_ready = !pend_valid;
    assign accept       = bus.in_valid && !pend_valid;
    assign done_now     = state == WAIT && !bus.tx_busy && byte_idx == LAST_IDX;
    frame_byte_sel #(.PAYLOAD_BYTES(PAYLOAD_BYTES), .SYNC_BYTE(SYNC_BYTE)) u_sel (
        .idx(byte_idx), .seq(bus.seq_num), .payload(act_payload), .checksum(act_chk), .byte_out(cur_byte)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            byte_idx       <= '0;
            act_payload    <= '0;
            act_chk        <= '0;
            pend_payload   <= '0;
            pend_chk       <= '0;
            pend_valid     <= 1'b0;
            bus.tx_data    <= '0;
            bus.tx_start   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.seq_num    <= '0;
            bus.drop_cnt   <= '0;
        end else begin
            bus.tx_start   <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.in_valid && pend_valid && !(&bus.drop_cnt)) bus.drop_cnt <= bus.drop_cnt + DROP_CNT_W'(1);
            // a sample arriving while a frame is in flight parks in PENDING, unless the frame ends this very edge
            if (accept && state != IDLE && !done_now) begin
                pend_payload <= bus.payload;
                pend_chk     <= bus.checksum;
                pend_valid   <= 1'b1;
            end
            case (state)
                IDLE: if (accept) begin
                    act_payload <= bus.payload;
                    act_chk     <= bus.checksum;
                    byte_idx    <= '0;
                    state       <= SEND;
                end
                SEND: if (!bus.tx_busy) begin
                    bus.tx_data  <= cur_byte;
                    bus.tx_start <= 1'b1;
                    state        <= GUARD;
                end
                GUARD: state <= WAIT;
                WAIT: if (!bus.tx_busy) begin
                    if (byte_idx == LAST_IDX) begin
                        bus.frame_done <= 1'b1;
                        bus.seq_num    <= bus.seq_num + 8'd1;
                        byte_idx       <= '0;
                        state          <= (pend_valid || accept) ? SEND : IDLE;
                        act_payload    <= pend_valid ? pend_payload : bus.payload;
                        act_chk        <= pend_valid ? pend_chk : bus.checksum;
                        pend_valid     <= 1'b0;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                        state    <= SEND;
                    end
                end
            endcase
        end
    end
endmodule
